// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, hazard FSM state type and rt-usage helper.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI7 = 6'h07;
  typedef enum logic {RUN, STALL} state_e;
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = (inc && count_q != '1) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, jump and taken-branch flush control for the 5-stage MIPS pipe.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_mem_read,
  input  logic             id_jump,
  input  logic             mem_branch_taken,
  output logic             control,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ex_ld_valid_q, ex_ld_valid_d;
  logic [4:0] ex_ld_rt_q, ex_ld_rt_d;
  logic       hazard, stall_inc, flush_inc;
  assign hazard = id_valid && ex_ld_valid_q && ex_ld_rt_q != '0 &&
                  (ex_ld_rt_q == id_rs || (uses_rt(id_opcode) && ex_ld_rt_q == id_rt));
  always_comb begin
    {control, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush} = 6'b111000;
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!rst_n) begin
      {control, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush} = 6'b000110;
    end else if (mem_branch_taken) begin
      {control, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush} = 6'b011111;
      state_d   = RUN;
      cnt_d     = '0;
      flush_inc = 1'b1;
    end else if (state_q == STALL) begin
      {control, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush} = 6'b000000;
      stall_inc = 1'b1;
      cnt_d     = cnt_q - 3'd1;
      state_d   = (cnt_q <= 3'd1) ? RUN : STALL;
    end else if (hazard) begin
      {control, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush} = 6'b000000;
      stall_inc = 1'b1;
      state_d   = (STALL_CYCLES > 1) ? STALL : RUN;
      cnt_d     = 3'(STALL_CYCLES - 1);
    end else if (id_valid && id_jump) begin
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
    end
    // a bubble or flush drops the load from the shadow, which is what ends the hazard
    ex_ld_valid_d = control && id_valid && id_mem_read && !idex_flush;
    ex_ld_rt_d    = id_rt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      ex_ld_valid_q <= 1'b0;
      ex_ld_rt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ex_ld_valid_q <= ex_ld_valid_d;
      ex_ld_rt_q    <= ex_ld_rt_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall_inc), .count(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(flush_inc), .count(flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two configurations (1-bubble/16-bit, 3-bubble/4-bit) against a bubble-budget reference model.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_mem_read = 1'b0;
  logic       id_jump = 1'b0;
  logic       mem_branch_taken = 1'b0;
  logic [5:0]  o_a, o_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;
  int n_vec = 0;
  int n_err = 0;
  int m_left[2], m_ldv[2], m_ldrt[2], m_sc[2], m_fc[2];

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_mem_read(id_mem_read), .id_jump(id_jump), .mem_branch_taken(mem_branch_taken),
    .control(o_a[5]), .pc_write(o_a[4]), .ifid_write(o_a[3]), .ifid_flush(o_a[2]),
    .idex_flush(o_a[1]), .exmem_flush(o_a[0]), .stall_cnt(sc_a), .flush_cnt(fc_a));

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_mem_read(id_mem_read), .id_jump(id_jump), .mem_branch_taken(mem_branch_taken),
    .control(o_b[5]), .pc_write(o_b[4]), .ifid_write(o_b[3]), .ifid_flush(o_b[2]),
    .idex_flush(o_b[1]), .exmem_flush(o_b[0]), .stall_cnt(sc_b), .flush_cnt(fc_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One cycle: drive, check each configuration against the model, then advance the model.
  task automatic cyc(input logic rn, input logic v, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic mr, input logic j, input logic br);
    @(negedge clk);
    {rst_n, id_valid, id_opcode, id_rs, id_rt, id_mem_read, id_jump, mem_branch_taken} =
      {rn, v, op, rs, rt, mr, j, br};
    #1;
    for (int k = 0; k < 2; k++) begin
      int bub = (k == 0) ? 1 : 3;
      int mx  = (k == 0) ? 65535 : 15;
      logic [5:0] exp;
      logic urt, hz;
      int ldv;
      urt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      hz  = v && m_ldv[k] != 0 && m_ldrt[k] != 0 &&
            (m_ldrt[k] == int'(rs) || (urt && m_ldrt[k] == int'(rt)));
      ldv = 0;
      chk(k ? "stall_cnt_b" : "stall_cnt_a", k ? 32'(sc_b) : 32'(sc_a), 32'(m_sc[k]));
      chk(k ? "flush_cnt_b" : "flush_cnt_a", k ? 32'(fc_b) : 32'(fc_a), 32'(m_fc[k]));
      if (!rn) begin
        exp = 6'b000110;
        m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else if (br) begin
        exp = 6'b011111;
        m_left[k] = 0;
        if (m_fc[k] < mx) m_fc[k]++;
      end else if (m_left[k] > 0 || hz) begin
        exp = 6'b000000;
        m_left[k] = (m_left[k] > 0) ? m_left[k] - 1 : bub - 1;
        if (m_sc[k] < mx) m_sc[k]++;
      end else if (v && j) begin
        exp = 6'b111100;
        ldv = int'(v && mr);
        if (m_fc[k] < mx) m_fc[k]++;
      end else begin
        exp = 6'b111000;
        ldv = int'(v && mr);
      end
      chk(k ? "outs_b" : "outs_a", 32'(k ? o_b : o_a), 32'(exp));
      m_ldv[k]  = ldv;
      m_ldrt[k] = rn ? int'(rt) : 0;
    end
  endtask

  task automatic idle();
    cyc(1, 0, 6'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    repeat (2) cyc(0, 1'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_ldv[k] = 0; m_ldrt[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    do_reset();
    idle();
    // load-use: lw $8 then add using rs=8, held in IF/ID while stalled
    cyc(1, 1, 6'h23, 1, 8, 1, 0, 0);
    repeat (4) cyc(1, 1, 6'h00, 8, 2, 0, 0, 0);
    idle();
    chk("lu_stall_a", 32'(sc_a), 32'd1);
    chk("lu_stall_b", 32'(sc_b), 32'd3);
    // $0 never hazards; addi does not read rt
    cyc(1, 1, 6'h23, 1, 0, 1, 0, 0);
    cyc(1, 1, 6'h00, 0, 0, 0, 0, 0);
    cyc(1, 1, 6'h23, 1, 9, 1, 0, 0);
    cyc(1, 1, 6'h07, 3, 9, 0, 0, 0);
    chk("no_false_a", 32'(sc_a), 32'd1);
    chk("no_false_b", 32'(sc_b), 32'd3);
    cyc(1, 1, 6'h02, 0, 0, 0, 1, 0);
    idle();
    chk("jump_fc_b", 32'(fc_b), 32'd1);
    // branch lands in the second STALL-state cycle of the 3-bubble configuration
    do_reset();
    cyc(1, 1, 6'h23, 1, 5, 1, 0, 0);
    cyc(1, 1, 6'h00, 5, 2, 0, 0, 0);
    cyc(1, 1, 6'h00, 5, 2, 0, 0, 0);
    cyc(1, 1, 6'h00, 5, 2, 0, 0, 1);
    cyc(1, 1, 6'h00, 5, 2, 0, 0, 0);
    chk("br_stall_b", 32'(sc_b), 32'd2);
    chk("br_flush_b", 32'(fc_b), 32'd1);
    // saturation of the 4-bit counter
    do_reset();
    repeat (20) cyc(1, 1, 6'h02, 0, 0, 0, 1, 0);
    idle();
    chk("sat_fc_b", 32'(fc_b), 32'd15);
    chk("sat_fc_a", 32'(fc_a), 32'd20);
    for (int i = 0; i < 600; i++) begin
      logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h07};
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0), ops[$urandom_range(0, 5)],
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath. It is the producer of the `control` enable that the main decoder consumes.
- Decides each cycle whether the ID-stage instruction proceeds (control=1) or becomes a bubble (control=0).
- Drives PC / IF-ID write enables and the stage flushes for load-use stalls, jumps (resolved in ID) and taken branches (resolved in MEM).
- Keeps saturating stall/flush event counters for debug.

Parameters:
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  6  IF/ID instr[31:26].
- id_rs  in  5  IF/ID instr[25:21].
- id_rt  in  5  IF/ID instr[20:16].
- id_mem_read  in  1  decoder MemRead for the ID instruction.
- id_jump  in  1  decoder jump for the ID instruction.
- mem_branch_taken  in  1  EX/MEM branch & zero.
- control  out  1  to decoder; 0 forces all control signals to 0 (bubble).
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to a nop.
- idex_flush  out  1  clear ID/EX control bits.
- exmem_flush  out  1  clear EX/MEM control bits.
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating.
- flush_cnt  out  CNT_W  jump + branch redirect events, saturating.

Behaviour:
- Reset: all registers update only on a rising clk edge with rst_n=0.
  - Next state: state=RUN, stall counter=0, shadow ex_ld_valid=0, ex_ld_rt=0, stall_cnt=0, flush_cnt=0.
  - While rst_n=0, outputs are forced to: control=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_flush=0.
- Outputs are combinational from state, shadow registers and inputs. Detection to response latency is 0 cycles.
- Shadow register: each edge, ex_ld_valid <= control & id_valid & id_mem_read & ~idex_flush, and ex_ld_rt <= id_rt. A bubble or flush therefore clears it.
- uses_rt(opcode) is 1 for R-type (0x00), sw (0x2B) and beq (0x04); it is 0 otherwise.
- hazard = id_valid & ex_ld_valid & (ex_ld_rt!=0) & ((ex_ld_rt==id_rs) | (uses_rt & ex_ld_rt==id_rt)).
- Priority each cycle: branch > load-use > jump > normal.
- Branch (mem_branch_taken=1, any state):
  - ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1, ifid_write=1, control=0.
  - Next state RUN; an in-progress stall is abandoned.
  - flush_cnt += 1.
- FSM states RUN and STALL:
  - RUN, hazard: control=0, pc_write=0, ifid_write=0, no flushes, stall_cnt += 1. Go to STALL with cnt=STALL_CYCLES-1 when STALL_CYCLES>1; otherwise stay in RUN. The cleared shadow ends the hazard.
  - STALL: same outputs as a hazard cycle, stall_cnt += 1, cnt -= 1. At cnt==0 go to RUN. The shadow does not reload while control=0.
  - RUN, no hazard, id_valid & id_jump: control=1, pc_write=1, ifid_write=1, ifid_flush=1 (kills the fall-through fetch), flush_cnt += 1.
  - RUN, otherwise: control=1, pc_write=1, ifid_write=1, all flushes 0.
- id_valid=0: never a hazard, never a jump, control=1.
- Counters saturate at 2^CNT_W-1. They never wrap.
- Simultaneous branch and hazard: branch wins; stall_cnt is not incremented.

Decomposition:
- Shared package mips_pkg: opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_J=6'h02, OP_ADDI7=6'h07; an FSM state enum {RUN, STALL}; a uses_rt function.
- One natural sub-module, sat_counter (parameter W; inputs inc, clk, rst_n), instantiated twice.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> control=0, pc_write=0, ifid_flush=1, idex_flush=1, counters 0. First cycle after release with idle inputs -> control=1, pc_write=1.
- Load-use: lw $8 accepted, then next ID add rs=8 -> exactly 1 cycle with control=0, pc_write=0, ifid_write=0; then control=1; stall_cnt=1. Repeat with STALL_CYCLES=3 -> 3 bubble cycles, stall_cnt=3.
- No false hazard: lw $0 then add rs=0 -> no stall. lw $9 then addi(0x07) rt=9, rs=3 -> no stall.
- Jump: id_jump=1, id_valid=1 -> ifid_flush=1, control=1, pc_write=1 for one cycle; flush_cnt=1.
- Branch during stall: enter STALL (STALL_CYCLES=3); assert mem_branch_taken in the 2nd stall cycle -> all three flushes=1, pc_write=1 that cycle, RUN next cycle; stall_cnt=2, flush_cnt=1.
- Saturation: CNT_W=4, 20 jumps -> flush_cnt holds at 15.
